// File: rtl/serial_addsub_pkg.sv
// Shared types and opcode encodings for the bit-serial adder/subtractor.
package serial_addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;
endpackage

// File: rtl/serial_addsub_fas.sv
// 1-bit full adder cell; subtraction is formed by the caller inverting b and seeding carry.
module serial_addsub_fas (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit two's-complement add/subtract with carry-out and signed overflow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         a_ns,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t           r_state;
  logic [N-1:0]     r_a, r_b, r_sh;
  logic             r_ns, r_carry, r_cmsb, r_last;
  logic [CNT_W-1:0] r_idx;
  logic             w_ai, w_bi, w_sum, w_co;

  assign w_ai = r_a[r_idx];
  assign w_bi = r_b[r_idx] ^ ~r_ns;

  serial_addsub_fas u_fas (
    .i_a  (w_ai),
    .i_b  (w_bi),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  // After the MSB is processed, RUN holds one extra cycle (r_last) before DONE,
  // so busy covers exactly the N bit cycles and done lands N+1 edges after start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_ns    <= 1'b0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_ns    <= a_ns;
            r_idx   <= '0;
            r_carry <= (a_ns == OP_SUB);
            r_last  <= 1'b0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (!r_last) begin
            r_sh    <= {w_sum, r_sh[N-1:1]};
            r_carry <= w_co;
            if (r_idx == CNT_W'(N-1)) begin
              r_cmsb <= r_carry;
              r_last <= 1'b1;
              busy   <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_last  <= 1'b0;
            r_state <= DONE;
            done    <= 1'b1;
            s       <= r_sh;
            cout    <= r_carry;
            ovf     <= r_cmsb ^ r_carry;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
